conv_sequencer: RTL and testbench

Control sequencer for the convolution datapath (`kernel_mem`, `shift_register`, `multiplier`). It accepts a start command, streams K×K kernel coefficients into kernel memory and then a raster-order image into the shift register. It gates shifting and multiplier updates under output backpressure, and marks which multiplier results are valid, fully-overlapped windows. It sits between the host-facing wrapper (Wishbone/LA) and the datapath.

---
 rtl/conv_sequencer_if.sv | 24 ++
 rtl/conv_sequencer.sv | 154 +++++++++++++++
 tb/tb_conv_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sequencer_if.sv
// Stream handshakes between the host-facing wrapper and the convolution sequencer:
// kernel coefficients in, image pixels in, result valid/ready out.
interface conv_sequencer_if #(
  parameter int BITS = 32
);
  logic            k_valid;
  logic            k_ready;
  logic [BITS-1:0] k_data;
  logic            px_valid;
  logic            px_ready;
  logic [BITS-1:0] px_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output k_valid, k_data, px_valid, px_data, out_ready,
    input  k_ready, px_ready, out_valid
  );

  modport slave (
    input  k_valid, k_data, px_valid, px_data, out_ready,
    output k_ready, px_ready, out_valid
  );
endinterface

// File: rtl/conv_sequencer.sv
// Sequences one convolution frame: loads K*K coefficients, streams a raster image,
// and tracks which multiplier results are fully-overlapped windows.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_IDLE   | waiting for start; start clears the datapath
//  S_LOAD_K | accepting K*K kernel coefficients into kernel_mem
//  S_STREAM | accepting W*H pixels, gated by output backpressure
//  S_DRAIN  | no pixel accepts; waits for the result pipeline to empty
//  S_FINISH | one-cycle done pulse
module conv_sequencer #(
  parameter int BITS        = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 128,
  parameter int IMG_HEIGHT  = 128
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  conv_sequencer_if.slave bus,
  output logic            kernel_write_en,
  output logic [BITS-1:0] kernel_data,
  output logic            shift_en,
  output logic [BITS-1:0] shift_data,
  output logic            mult_en,
  output logic            dp_clear,
  output logic            busy,
  output logic            done
);

  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int KW = $clog2(KK + 1);
  localparam int CW = $clog2(IMG_LENGTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [KW-1:0] K_LAST   = KW'(KK - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_LENGTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_STREAM,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_cnt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            v1, v2;
  logic            stall, last_coef, last_px, win;
  logic            k_rdy, px_rdy;

  assign stall         = v2 & ~bus.out_ready;
  assign last_coef     = (k_cnt == K_LAST);
  assign last_px       = (row == ROW_LAST) && (col == COL_LAST);
  // Bottom-right-corner convention: the window is complete once the
  // pixel at (row, col) with both indices >= K-1 has been shifted in.
  assign win           = (row >= ROW_WIN) && (col >= COL_WIN);

  assign bus.out_valid = v2;
  assign bus.k_ready   = k_rdy;
  assign bus.px_ready  = px_rdy;
  assign kernel_data   = bus.k_data;
  assign shift_data    = bus.px_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    k_rdy           = 1'b0;
    px_rdy          = 1'b0;
    mult_en         = 1'b0;
    dp_clear        = 1'b0;
    done            = 1'b0;
    busy            = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_K;
          dp_clear = 1'b1;
        end
      end
      S_LOAD_K: begin
        k_rdy = 1'b1;
        if (bus.k_valid && last_coef) state_d = S_STREAM;
      end
      S_STREAM: begin
        px_rdy  = ~stall;
        mult_en = ~stall;
        if (bus.px_valid && !stall && last_px) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        mult_en = ~stall;
        if (!v1 && (!v2 || bus.out_ready)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; no handshake may complete in that cycle.
    if (abort) begin
      state_d  = S_IDLE;
      dp_clear = 1'b1;
      k_rdy    = 1'b0;
      px_rdy   = 1'b0;
      done     = 1'b0;
    end
    kernel_write_en = bus.k_valid & k_rdy;
    shift_en        = bus.px_valid & px_rdy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_cnt <= '0;
      col   <= '0;
      row   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
    end else if (dp_clear) begin
      k_cnt <= '0;
      col   <= '0;
      row   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
    end else begin
      if (kernel_write_en) k_cnt <= k_cnt + KW'(1);
      // Counters park on the last pixel rather than wrapping into a new frame.
      if (shift_en && !last_px) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (mult_en) begin
        v1 <= shift_en & win;
        v2 <= v1;
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized frame-level bench for conv_sequencer (K=3, W=H=4) against a
// cycle model built from frame counts and a two-deep result delay line.
module tb_conv_sequencer;
  localparam int BITS = 32;
  localparam int K    = 3;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int KK   = K * K;
  localparam int NPX  = W * H;

  localparam int M_FULL  = 0;
  localparam int M_THR   = 1;
  localparam int M_BP    = 2;
  localparam int M_ABORT = 3;
  localparam int M_RESET = 4;
  localparam int M_SPUR  = 5;
  localparam int M_RAND  = 6;

  logic clk = 1'b0;
  logic reset_n, start, abort;
  logic kernel_write_en, shift_en, mult_en, dp_clear, busy, done;
  logic [BITS-1:0] kernel_data, shift_data;

  conv_sequencer_if #(.BITS(BITS)) bus ();

  conv_sequencer #(
    .BITS(BITS), .KERNEL_SIZE(K), .IMG_LENGTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .bus(bus),
    .kernel_write_en(kernel_write_en), .kernel_data(kernel_data),
    .shift_en(shift_en), .shift_data(shift_data), .mult_en(mult_en),
    .dp_clear(dp_clear), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fail_cnt  = 0;

  // frame model: counts of words taken, plus results in flight
  bit m_active, m_fin, pipe0, pipe1;
  int k_got, px_got;
  int obs_outs, obs_done;
  int mode, bp_left;
  bit kv_tog, bp_used, aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_window(input int p);
    return ((p / W) >= K - 1) && ((p % W) >= K - 1);
  endfunction

  task automatic model_reset();
    m_active = 0; m_fin = 0; pipe0 = 0; pipe1 = 0; k_got = 0; px_got = 0;
  endtask

  task automatic do_cycle();
    bit stall, in_px, draining, e_kr, e_pr, e_kwe, e_shift, e_mult, e_done, e_clr;
    @(negedge clk);
    stall   = pipe1 && !bus.out_ready;
    in_px   = m_active && !m_fin && (k_got == KK);
    e_kr    = m_active && !m_fin && (k_got < KK) && !abort;
    e_pr    = in_px && (px_got < NPX) && !stall && !abort;
    e_kwe   = e_kr && bus.k_valid;
    e_shift = e_pr && bus.px_valid;
    e_mult  = in_px && !stall;
    e_done  = m_fin && !abort;
    e_clr   = abort || (!m_active && start);
    check("k_ready", bus.k_ready, e_kr);
    check("px_ready", bus.px_ready, e_pr);
    check("kernel_write_en", kernel_write_en, e_kwe);
    check("shift_en", shift_en, e_shift);
    check("mult_en", mult_en, e_mult);
    check("out_valid", bus.out_valid, pipe1);
    check("busy", busy, m_active);
    check("done", done, e_done);
    check("dp_clear", dp_clear, e_clr);
    check("kernel_data", kernel_data, bus.k_data);
    check("shift_data", shift_data, bus.px_data);
    if (bus.out_valid && bus.out_ready) obs_outs++;
    if (done) obs_done++;
    if (abort) begin
      m_active = 0; m_fin = 0; pipe0 = 0; pipe1 = 0;
    end else if (!m_active) begin
      if (start) begin
        model_reset();
        m_active = 1;
      end
    end else if (m_fin) begin
      m_active = 0; m_fin = 0;
    end else begin
      if (e_kwe) k_got++;
      if (in_px && !stall) begin
        draining = (px_got == NPX);
        pipe1 = pipe0;
        pipe0 = e_shift && is_window(px_got);
        if (e_shift) px_got++;
        if (draining && !pipe0 && !pipe1) m_fin = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive();
    bus.k_data  = $urandom;
    bus.px_data = $urandom;
    case (mode)
      M_THR:   begin kv_tog = !kv_tog; bus.k_valid = kv_tog; end
      M_RAND:  bus.k_valid = 1'($urandom_range(0, 1));
      default: bus.k_valid = 1'b1;
    endcase
    bus.px_valid = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mode == M_BP && pipe1 && !bp_used) begin
      bp_used = 1; bp_left = 5;
    end
    if (bp_left > 0) begin
      bus.out_ready = 1'b0; bp_left--;
    end else begin
      bus.out_ready = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    abort = (mode == M_ABORT) && (px_got == 8) && !aborted;
    if (abort) aborted = 1;
    start = (mode == M_SPUR) && m_active && ($urandom_range(0, 2) == 0);
  endtask

  task automatic run_frame(input int m);
    int n, outs_before;
    mode = m; kv_tog = 0; bp_used = 0; bp_left = 0; aborted = 0;
    obs_outs = 0; obs_done = 0;
    drive();
    start = 1'b1; abort = 1'b0;
    do_cycle();
    start = 1'b0;
    n = 0;
    while (m_active && n < 300) begin
      drive();
      if (mode == M_RESET && k_got == KK && px_got == NPX && !m_fin) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_px_ready", bus.px_ready, 1'b0);
        check("rst_mult_en", mult_en, 1'b0);
        model_reset();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        break;
      end
      do_cycle();
      n++;
    end
    check("frame_terminates", m_active, 1'b0);
    case (m)
      M_ABORT: begin
        check("abort_outs", obs_outs, 0);
        check("abort_done", obs_done, 0);
      end
      M_RESET: check("reset_done", obs_done, 0);
      default: begin
        check("frame_outs", obs_outs, (H - K + 1) * (W - K + 1));
        check("frame_done", obs_done, 1);
      end
    endcase
    mode = M_FULL;
    outs_before = obs_outs;
    repeat (3) begin
      drive();
      do_cycle();
    end
    check("idle_no_out", obs_outs, outs_before);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.k_valid = 1'b1; bus.px_valid = 1'b1; bus.out_ready = 1'b1;
    bus.k_data = 32'h1234_5678; bus.px_data = 32'h9abc_def0;
    model_reset();
    mode = M_FULL; bp_left = 0;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_k_ready", bus.k_ready, 1'b0);
    check("reset_px_ready", bus.px_ready, 1'b0);
    check("reset_kwe", kernel_write_en, 1'b0);
    check("reset_shift_en", shift_en, 1'b0);
    check("reset_mult_en", mult_en, 1'b0);
    check("reset_dp_clear", dp_clear, 1'b0);
    check("reset_kernel_data", kernel_data, 32'h1234_5678);
    check("reset_shift_data", shift_data, 32'h9abc_def0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin drive(); do_cycle(); end

    // start together with abort in IDLE must not leave IDLE
    drive();
    start = 1'b1; abort = 1'b1;
    do_cycle();
    start = 1'b0; abort = 1'b0;
    drive();
    do_cycle();
    check("start_abort_idle", busy, 1'b0);

    run_frame(M_FULL);
    run_frame(M_THR);
    run_frame(M_BP);
    run_frame(M_ABORT);
    run_frame(M_FULL);
    run_frame(M_RESET);
    run_frame(M_SPUR);
    repeat (6) run_frame(M_RAND);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
